// File: rtl/switch_scan_ctrl.sv
// switch_scan_ctrl: frame sequencer for the external PISO switch chain.
// Each frame loads the external register, shifts NBITS bits in, then in a
// single UPDATE cycle publishes the DIP word, debounces the five buttons and
// queues press/release events for a valid/ready consumer.
// Serial frame layout (k = bit counter, first bit k=0):
//   k 0..7   -> dip[15:8]   (dip[8+k])
//   k 8..15  -> dip[7:0]    (dip[k-8])
//   k 16..20 -> raw buttons (raw[k-16])
module switch_scan_ctrl #(
  parameter int NBITS     = 21,
  parameter int DEBOUNCE  = 4,
  parameter int FRAME_GAP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_in,
  output logic        sh_ld,
  output logic        sh_en,
  input  logic        start,
  input  logic        auto_en,
  output logic        busy,
  output logic [15:0] dip,
  output logic [4:0]  btn,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [4:0]  evt_press,
  output logic [4:0]  evt_release,
  output logic        evt_ovf
);

  localparam int NBTN = 5;
  // Last value of the shared cycle counter in SHIFT and GAP respectively.
  localparam logic [4:0] BIT_LAST = 5'(NBITS - 1);
  localparam logic [4:0] GAP_LAST = 5'((FRAME_GAP > 0) ? (FRAME_GAP - 1) : 0);
  localparam logic [3:0] DB_MAX   = 4'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_UPDATE,
    S_GAP
  } state_t;

  state_t                  state_reg, state_next;
  logic [4:0]              cyc_cnt_reg, cyc_cnt_next;
  logic                    start_pend_reg, start_pend_next;
  logic [NBITS-1:0]        shadow_reg;
  logic [15:0]             dip_reg;
  logic [NBTN-1:0]         btn_reg;
  logic [NBTN-1:0][3:0]    cnt_reg;
  logic [NBTN-1:0]         evt_press_reg, evt_release_reg;
  logic                    evt_ovf_reg;

  logic                    keep_going;
  logic [NBTN-1:0]         raw;
  logic [NBTN-1:0]         btn_upd;
  logic [NBTN-1:0][3:0]    cnt_upd;
  logic [NBTN-1:0]         press_bits, release_bits;
  logic                    is_update, new_evt, accept;

  // Another frame follows the current one if free-running or a start is queued.
  assign keep_going = auto_en | start_pend_reg;

  // State, cycle counter and start-pending flag; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cyc_cnt_reg    <= '0;
      start_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      start_pend_reg <= start_pend_next;
    end
  end

  // Next-state logic and shift-register control outputs.
  always_comb begin
    state_next      = state_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    start_pend_next = start_pend_reg;
    sh_ld           = 1'b1;
    sh_en           = 1'b0;
    busy            = 1'b1;
    case (state_reg)
      S_IDLE: begin
        busy         = 1'b0;
        cyc_cnt_next = '0;
        if (start || keep_going) state_next = S_LOAD;
      end
      S_LOAD: begin
        sh_ld        = 1'b0;
        cyc_cnt_next = '0;
        state_next   = S_SHIFT;
      end
      S_SHIFT: begin
        sh_en = 1'b1;
        if (cyc_cnt_reg == BIT_LAST) begin
          cyc_cnt_next = '0;
          state_next   = S_UPDATE;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 5'd1;
        end
      end
      S_UPDATE: begin
        cyc_cnt_next = '0;
        if (FRAME_GAP == 0) state_next = keep_going ? S_LOAD : S_IDLE;
        else                state_next = S_GAP;
      end
      S_GAP: begin
        if (cyc_cnt_reg == GAP_LAST) begin
          cyc_cnt_next = '0;
          state_next   = keep_going ? S_LOAD : S_IDLE;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 5'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A frame being launched consumes the queued start; any start seen while
    // a frame is running queues exactly one more (repeats collapse).
    if (state_next == S_LOAD && state_reg != S_LOAD && state_reg != S_SHIFT)
      start_pend_next = 1'b0;
    else if (start && busy)
      start_pend_next = 1'b1;
  end

  // Capture one serial bit per SHIFT cycle into the frame shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg <= '0;
    end else if (state_reg == S_SHIFT) begin
      shadow_reg[cyc_cnt_reg] <= ser_in;
    end
  end

  assign raw       = shadow_reg[20:16];
  assign is_update = (state_reg == S_UPDATE);

  // Per-button debounce: a button flips only after DEBOUNCE consecutive
  // frames disagreeing with its current level; any agreeing frame restarts it.
  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic       differs;
      logic       hit;
      logic [3:0] cnt_inc;
      assign differs      = raw[gi] ^ btn_reg[gi];
      assign cnt_inc      = cnt_reg[gi] + 4'd1;
      assign hit          = differs && (cnt_inc == DB_MAX);
      assign btn_upd[gi]  = hit ? raw[gi] : btn_reg[gi];
      assign cnt_upd[gi]  = (differs && !hit) ? cnt_inc : 4'd0;
    end
  endgenerate

  // Publish the DIP word and debounced button state once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dip_reg <= '0;
      btn_reg <= '0;
      cnt_reg <= '0;
    end else if (is_update) begin
      dip_reg <= {shadow_reg[7:0], shadow_reg[15:8]};
      btn_reg <= btn_upd;
      cnt_reg <= cnt_upd;
    end
  end

  assign press_bits   = btn_upd & ~btn_reg;
  assign release_bits = ~btn_upd & btn_reg;
  assign new_evt      = is_update && ((press_bits | release_bits) != '0);
  assign evt_valid    = (evt_press_reg | evt_release_reg) != '0;
  assign accept       = evt_valid && evt_ready;

  // Pending event registers: merge new edges, clear on accept, and when both
  // happen together keep only the new edges so nothing is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_press_reg   <= '0;
      evt_release_reg <= '0;
      evt_ovf_reg     <= 1'b0;
    end else if (new_evt) begin
      if (accept) begin
        evt_press_reg   <= press_bits;
        evt_release_reg <= release_bits;
      end else begin
        evt_press_reg   <= evt_press_reg | press_bits;
        evt_release_reg <= evt_release_reg | release_bits;
        if (evt_valid) evt_ovf_reg <= 1'b1;
      end
    end else if (accept) begin
      evt_press_reg   <= '0;
      evt_release_reg <= '0;
    end
  end

  assign dip         = dip_reg;
  assign btn         = btn_reg;
  assign evt_press   = evt_press_reg;
  assign evt_release = evt_release_reg;
  assign evt_ovf     = evt_ovf_reg;

endmodule

// File: doc/switch_scan_ctrl.md
# switch_scan_ctrl

Scan controller for the board's serial switch chain: 16 DIP switches plus 5 push buttons, read through an external parallel-in/serial-out shift register. It sequences the load/shift pulses, deserialises each frame, and publishes the DIP word directly. Push buttons are debounced across frames, and press/release events go to downstream logic over a valid/ready handshake. It replaces free-running scanning with a start/auto-scheduled frame sequencer.

## Interface
- `NBITS`, 21: bits per frame. Fixed layout is 16 DIP bits, then 5 button bits.
- `DEBOUNCE`, 4: number of consecutive agreeing frames needed before a button state changes. Range 1..15.
- `FRAME_GAP`, 3: idle cycles after each frame, with `sh_ld`=1 and `sh_en`=0. Range 0..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ser_in`  in  1  serial data from the external chain.
- `sh_ld`  out  1  0 = parallel load of the external register; 1 = shift/hold.
- `sh_en`  out  1  shift enable for the external register.
- `start`  in  1  one-cycle request for a single frame.
- `auto_en`  in  1  level; while high, frames run back to back.
- `busy`  out  1  high from LOAD through GAP.
- `dip`  out  16  latest DIP word.
- `btn`  out  5  debounced button levels.
- `evt_valid`  out  1  pending event available.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_press`  out  5  buttons that went 0→1 since the last accept.
- `evt_release`  out  5  buttons that went 1→0 since the last accept.
- `evt_ovf`  out  1  sticky flag: an event was merged into an unconsumed one.

## Operation
- The FSM has five states: IDLE, LOAD, SHIFT, UPDATE, GAP.
- IDLE
  - `sh_ld`=1, `sh_en`=0, `busy`=0.
  - Go to LOAD when `start`, `auto_en`, or the `start_pend` flag is high. Clear `start_pend` on that transition.
- LOAD: one cycle, `sh_ld`=0, `sh_en`=0, then go to SHIFT.
- SHIFT: NBITS cycles, `sh_ld`=1, `sh_en`=1.
  - Sample `ser_in` into the frame shadow at each rising edge, using bit counter k = 0..20.
  - Bit mapping:
    - k 0..7 → `dip[8+k]`
    - k 8..15 → `dip[k-8]`
    - k 16..20 → `raw[k-16]`
  - After k=20, go to UPDATE.
- UPDATE: one cycle.
  - `dip` ← shadow DIP bits. No debounce is applied.
  - Per button i:
    - If `raw[i]==btn[i]`, `cnt[i]`←0.
    - Otherwise, `cnt[i]`←`cnt[i]`+1.
    - When that increment reaches DEBOUNCE: `btn[i]`←`raw[i]`, `cnt[i]`←0.
  - Then go to GAP, or to LOAD directly if FRAME_GAP=0.
- GAP: FRAME_GAP cycles.
  - Then go to LOAD if `auto_en` or `start_pend` is high, else IDLE.
- A `start` asserted while `busy` sets `start_pend`, so exactly one extra frame runs. Multiple `start`s during one frame collapse into one.
- Events
  - On UPDATE, `p` = bits of `btn` going 0→1 and `r` = bits going 1→0.
  - Pending registers: `evt_press` |= `p`, `evt_release` |= `r`.
  - `evt_valid` = OR of both pending registers.
- Accept rule:
  - On `evt_valid && evt_ready`, the pending registers are cleared.
  - If an accept and an UPDATE with nonzero `p`/`r` happen in the same cycle, the pending registers load `p`/`r` rather than clearing. No event is lost.
- Overflow: `evt_ovf` is set when UPDATE produces nonzero `p`/`r` while `evt_valid`=1 and the same cycle is not an accept. It is cleared only by `rst`.
- Outputs are stable between UPDATEs. `evt_*` change only on UPDATE or accept.

## Timing
- Frame length is 1 + NBITS + 1 + FRAME_GAP cycles; 26 cycles at the defaults.
- `start` in IDLE at edge t gives LOAD during cycle t+1, first sample at t+2, and UPDATE during cycle t+23.
- `dip`/`btn`/`evt_valid` update at the end of the UPDATE cycle.
- `start`→`dip` latency is 23 cycles.
- `evt_valid` stays asserted until accepted. `evt_ready` with no event pending is ignored.
- Reset values:
  - `sh_ld`=1
  - `sh_en`=0, `busy`=0
  - `dip`=0, `btn`=0, `cnt`=0, `start_pend`=0
  - `evt_valid`=0, `evt_press`=0, `evt_release`=0, `evt_ovf`=0
  - FSM=IDLE
- Reset asserted mid-frame discards the frame immediately and asynchronously. No partial `dip` update occurs.
- Dropping `auto_en` mid-frame completes the current frame, then returns to IDLE.

## Test plan
- Single-frame DIP mapping: pulse `start`, drive serial pattern 0xA5 for k0..7, 0x3C for k8..15, 0 for the buttons. Expect `dip`=16'hA53C after 23 cycles, `busy` low after 26, `evt_valid`=0.
- Debounce: `auto_en`=1, drive button 2 as 1 for 3 frames, then 0, then 1 for 4 frames. Expect `btn[2]` rising only at the end of the 4th consecutive frame, then `evt_press`=5'b00100 with `evt_valid`=1.
- Handshake and merge:
  - Hold `evt_ready`=0 across a press of button 0 and then a press of button 1.
  - Expect `evt_press`=5'b00011 and `evt_ovf`=1.
  - Assert `evt_ready` for one cycle; expect `evt_valid`=0 the next cycle.
- Simultaneous accept and new event: align `evt_ready`=1 with the UPDATE that releases button 0. Expect `evt_release`=5'b00001, `evt_valid`=1, `evt_ovf`=0.
- `start` during busy: pulse `start` twice mid-frame. Expect exactly two frames (52 cycles of `busy` at FRAME_GAP=3), then IDLE.
- Reset mid-SHIFT: assert `rst` at k=10. Expect `sh_ld`=1, `sh_en`=0 and `busy`=0 immediately, `dip` unchanged from its reset value 0, and a following `start` producing a normal frame.
